seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result bit width (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division, sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  unsigned dividend, captured when start is accepted.
REQ-006 SHALL have port divisor  input  WIDTH  unsigned divisor, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high while a division is in progress (RUN or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  WIDTH  unsigned quotient, held until next accepted start.
REQ-010 SHALL have port remainder  output  WIDTH  unsigned remainder, held until next accepted start.
REQ-011 SHALL have port div_zero  output  1  set with done when captured divisor is 0, held with results.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL capture operands, clear quotient/remainder/div_zero, and go to RUN (divisor!=0) or DONE (divisor==0).
REQ-014 RUN SHALL perform exactly WIDTH restoring iterations, one per clock, MSB of dividend first, then go to DONE.
REQ-015 Each iteration: partial remainder (WIDTH+1 bits) shifted left with next dividend bit; trial = partial - divisor, computed as partial + ~divisor + 1 via ripple subtract.
REQ-016 Trial carry-out 1 (no borrow) SHALL keep trial and shift quotient bit 1; carry-out 0 SHALL restore partial and shift quotient bit 0.
REQ-017 DONE SHALL assert done for exactly one cycle, drive final quotient/remainder, then return to IDLE.
REQ-018 Latency: with divisor!=0, done SHALL be high in the cycle following the (WIDTH+1)th rising edge after the edge that accepted start; with divisor==0, following the 1st edge.
REQ-019 Divide by zero SHALL give quotient all ones, remainder = dividend, div_zero=1.
REQ-020 start while busy SHALL be ignored; operands changing while busy SHALL not affect the result.
REQ-021 start high in the DONE cycle SHALL be ignored; back-to-back start accepted no earlier than the first IDLE cycle.
REQ-022 dividend < divisor SHALL give quotient 0, remainder = dividend, normal latency.
REQ-023 Outputs quotient/remainder/div_zero SHALL change only on an accepted start (clear) or DONE entry (load).

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, internal registers 0.
REQ-025 rst asserted mid-RUN SHALL abort the division; no done pulse SHALL follow after rst deasserts.
REQ-026 First start SHALL be accepted on the first rising edge with rst low.

Structure
REQ-027 Shared package SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2, 2 bits) and WIDTH default constant.
REQ-028 Trial subtraction SHALL be one sub-module, sub_trial (WIDTH+1 bits, ripple of full_adder cells, outputs difference and carry-out).
REQ-029 Iteration counter SHALL be $clog2(WIDTH)+1 bits, down-counting from WIDTH to 0.

Verification
REQ-030 100/7 -> done after 9 edges, quotient=14, remainder=2, div_zero=0.
REQ-031 255/1 then 3/10 back-to-back -> q=255 r=0, then q=0 r=3, each with 9-edge latency.
REQ-032 5/0 -> done 1 edge later, quotient=255, remainder=5, div_zero=1.
REQ-033 200/9 started, start pulsed with 50/5 at cycle 3 -> only q=22 r=2 reported, one done pulse.
REQ-034 rst at cycle 4 of 100/7 -> all outputs 0 immediately, no done pulse; subsequent 9/3 -> q=3 r=0.
REQ-035 Random 10,000 operand pairs vs reference model (q=a/b, r=a%b, b!=0), WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   WidthDefault : default operand/result width
//   StIdle/StRun/StDone : 2-bit controller state encoding
package seq_divider_pkg;

  localparam int unsigned WidthDefault = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/sub_trial.sv
// Trial subtraction for one restoring-division step: a_i - b_i computed as
// a_i + ~b_i + 1 through a ripple chain of full-adder cells.
//   a_i    : minuend (partial remainder)
//   b_i    : subtrahend (zero-extended divisor)
//   diff_o : difference
//   cout_o : carry-out; 1 means no borrow (a_i >= b_i)
module sub_trial #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         cout_o
);

  logic [N:0]   carry;
  logic [N-1:0] b_n;

  assign b_n      = ~b_i;
  assign carry[0] = 1'b1;  // the +1 of the two's-complement negate

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign diff_o[i]  = a_i[i] ^ b_n[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_n[i]) | (carry[i] & (a_i[i] ^ b_n[i]));
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a division (sampled in IDLE only)
//   dividend, divisor   : operands, captured when start is accepted
//   busy                : division in progress (RUN or DONE)
//   done                : one-cycle pulse, results valid
//   quotient, remainder : results, held until the next accepted start
//   div_zero            : captured divisor was zero
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   shifted, trial, part_next;
  logic             trial_cout;
  logic [WIDTH-1:0] quo_next;

  // Bring the next dividend bit (MSB first) into the partial remainder.
  assign shifted = {part_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  sub_trial #(
    .N(WIDTH + 1)
  ) u_trial (
    .a_i   (shifted),
    .b_i   ({1'b0, dvs_q}),
    .diff_o(trial),
    .cout_o(trial_cout)
  );

  // No borrow keeps the trial difference; a borrow restores the shifted value.
  assign part_next = trial_cout ? trial : shifted;
  assign quo_next  = {quo_q[WIDTH-2:0], trial_cout};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    part_d      = part_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d       = dividend;
          dvs_d       = divisor;
          part_d      = '0;
          quo_d       = '0;
          cnt_d       = CntW'(WIDTH);
          quotient_d  = '0;
          remainder_d = '0;
          div_zero_d  = 1'b0;
          if (divisor == '0) begin
            // Results are known immediately; skip the iterations.
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        part_d = part_next;
        quo_d  = quo_next;
        dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          // Last iteration: publish results as DONE is entered.
          state_d     = StDone;
          quotient_d  = quo_next;
          remainder_d = part_next[WIDTH-1:0];
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      part_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule
